key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable clk cycles required to accept a level change (20 ms at 50 MHz).
REQ-003 SHALL have parameter REPEAT_DELAY, default 25_000_000: held cycles before the first repeat pulse; 0 disables repeat.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 5_000_000: cycles between subsequent repeat pulses; legal range >= 1.
REQ-005 SHALL have port clk, input, 1: system clock, 50 MHz nominal.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port key_n_i, input, NUM_KEYS: raw asynchronous key pins, 0 = pressed.
REQ-008 SHALL have port key_level_o, output, NUM_KEYS: debounced state, 1 = pressed.
REQ-009 SHALL have port key_press_o, output, NUM_KEYS: one-cycle pulse on accepted press.
REQ-010 SHALL have port key_release_o, output, NUM_KEYS: one-cycle pulse on accepted release.
REQ-011 SHALL have port key_repeat_o, output, NUM_KEYS: one-cycle auto-repeat pulse while held.

Function
REQ-012 Each key_n_i bit SHALL pass through a 2-flop synchronizer; inverted synchronized value = sample.
REQ-013 Per channel, a debounce counter SHALL increment each cycle sample != key_level_o and clear to 0 any cycle sample == key_level_o.
REQ-014 When the counter equals DEBOUNCE_CYCLES-1 and sample still differs, key_level_o SHALL toggle at the next edge and the counter SHALL clear.
REQ-015 Latency raw edge -> key_level_o change SHALL be exactly DEBOUNCE_CYCLES+2 cycles for a clean edge.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES cycles (after sync) SHALL produce no output change and no pulse.
REQ-017 key_press_o/key_release_o SHALL assert in the same cycle key_level_o becomes 1/0, for exactly one cycle.
REQ-018 Per-channel FSM states: RELEASED, HELD_WAIT, HELD_REPEAT; RELEASED->HELD_WAIT on accepted press; HELD_WAIT->HELD_REPEAT when hold counter reaches REPEAT_DELAY; any held state->RELEASED on accepted release.
REQ-019 Hold counter SHALL clear on accepted press; first key_repeat_o pulse SHALL occur REPEAT_DELAY cycles after key_press_o, then every REPEAT_PERIOD cycles while held.
REQ-020 With REPEAT_DELAY=0 the FSM SHALL stay in HELD_WAIT and key_repeat_o SHALL never assert.
REQ-021 Release accepted in the same cycle a repeat is due SHALL emit key_release_o only; no repeat pulse.
REQ-022 Counters SHALL be sized $clog2(max parameter)+1 bits and SHALL never wrap; hold counter saturates outside HELD states.
REQ-023 Channels SHALL be fully independent; simultaneous events on multiple keys SHALL each produce their own pulses in the same cycle.

Reset
REQ-024 On rst_n low, synchronizer flops SHALL reset to 1 (released), all counters to 0, FSMs to RELEASED, all outputs to 0.
REQ-025 Reset mid-hold SHALL not generate key_release_o; after deassertion a still-pressed key SHALL be re-accepted as a fresh press after DEBOUNCE_CYCLES+2 cycles.

Structure
REQ-026 Shared package key_pkg SHALL hold the channel state enum (RELEASED, HELD_WAIT, HELD_REPEAT) and default timing constants.
REQ-027 One sub-module key_debounce_ch (sync, debounce, FSM for one key) SHALL be instantiated NUM_KEYS times via generate.

Verification (bench params DEBOUNCE_CYCLES=8, REPEAT_DELAY=32, REPEAT_PERIOD=10)
REQ-028 Clean press on key 0 held 20 cycles -> key_level_o[0]=1 exactly 10 cycles after edge, one key_press_o[0] pulse, no repeat.
REQ-029 Bounce: key 1 toggling every 3 cycles for 30 cycles then low -> single press pulse 10 cycles after last edge; 5-cycle glitch -> nothing.
REQ-030 Key 2 held 80 cycles -> repeat pulses at press+32, +42, +52, +62, +72; release pulse after release debounce.
REQ-031 Release timed to land on press+42 -> key_release_o only, no repeat that cycle.
REQ-032 rst_n pulsed low while key 3 held -> all outputs 0, no release pulse; press re-accepted 10 cycles after deassertion.
REQ-033 Keys 0 and 3 pressed same cycle -> both press pulses in the same cycle.

Source files
------------

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared channel state type, default timing and counter sizing for the key debouncer
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_WAIT   = 2'd1,
    HELD_REPEAT = 2'd2
  } key_state_t;

  localparam int DEF_NUM_KEYS        = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_PERIOD   = 5_000_000;

  // One extra bit above the largest timing constant keeps every counter clear of wrap.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 1) m = 1;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// rtl/key_debouncer_if.sv - key pin and debounced event bundle, W channels wide
interface key_debouncer_if #(
  parameter int W = 1
);
  logic [W-1:0] key_n;
  logic [W-1:0] key_level;
  logic [W-1:0] key_press;
  logic [W-1:0] key_release;
  logic [W-1:0] key_repeat;

  modport master (
    input  key_n,
    output key_level,
    output key_press,
    output key_release,
    output key_repeat
  );

  modport slave (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_repeat
  );
endinterface

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key: 2-flop sync, stable-count debounce, press/release/repeat FSM
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            rst_n,
  key_debouncer_if.master ch
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEB_LAST  = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t RD_LAST   = (REPEAT_DELAY > 0) ? cnt_t'(REPEAT_DELAY - 1) : '0;
  localparam cnt_t RP_LAST   = cnt_t'(REPEAT_PERIOD - 1);
  localparam bit   REPEAT_EN = (REPEAT_DELAY > 0);

  logic [1:0] sync_q;
  logic       sample;
  logic       level_q;
  cnt_t       deb_cnt;
  logic       accept;
  logic       press_ev;
  logic       release_ev;

  key_state_t state_q, state_d;
  cnt_t       hold_q, hold_d;
  logic       repeat_due;

  logic press_q, release_q, repeat_q;

  // Synchronizer idles at 1 so a reset looks like a released key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], ch.key_n};
    end
  end

  assign sample     = ~sync_q[1];
  assign accept     = (sample != level_q) && (deb_cnt == DEB_LAST);
  assign press_ev   = accept && sample;
  assign release_ev = accept && !sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      deb_cnt <= '0;
    end else if (sample != level_q) begin
      if (accept) begin
        level_q <= sample;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + cnt_t'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // A release landing on a due repeat wins: the repeat branch is never reached.
  always_comb begin
    state_d    = state_q;
    hold_d     = (hold_q == '1) ? hold_q : hold_q + cnt_t'(1);
    repeat_due = 1'b0;
    case (state_q)
      RELEASED: begin
        if (press_ev) begin
          state_d = HELD_WAIT;
          hold_d  = '0;
        end
      end
      HELD_WAIT: begin
        if (release_ev) begin
          state_d = RELEASED;
        end else if (REPEAT_EN && hold_q == RD_LAST) begin
          state_d    = HELD_REPEAT;
          hold_d     = '0;
          repeat_due = 1'b1;
        end
      end
      HELD_REPEAT: begin
        if (release_ev) begin
          state_d = RELEASED;
        end else if (hold_q == RP_LAST) begin
          hold_d     = '0;
          repeat_due = 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      press_q   <= press_ev;
      release_q <= release_ev;
      repeat_q  <= repeat_due;
    end
  end

  assign ch.key_level   = level_q;
  assign ch.key_press   = press_q;
  assign ch.key_release = release_q;
  assign ch.key_repeat  = repeat_q;

endmodule

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - NUM_KEYS independent debounced key channels with auto-repeat
module key_debouncer
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n_i,
  output logic [NUM_KEYS-1:0] key_level_o,
  output logic [NUM_KEYS-1:0] key_press_o,
  output logic [NUM_KEYS-1:0] key_release_o,
  output logic [NUM_KEYS-1:0] key_repeat_o
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debouncer_if #(.W(1)) ch_if ();

    assign ch_if.key_n = key_n_i[i];

    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .ch    (ch_if)
    );

    assign key_level_o[i]   = ch_if.key_level;
    assign key_press_o[i]   = ch_if.key_press;
    assign key_release_o[i] = ch_if.key_release;
    assign key_repeat_o[i]  = ch_if.key_repeat;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - self-checking bench for key_debouncer with a history-based reference model
module tb_key_debouncer;

  localparam int NK   = 4;
  localparam int DEB  = 8;
  localparam int RD   = 32;
  localparam int RP   = 10;
  localparam int HMAX = 16384;

  logic clk;
  logic rst_n;

  key_debouncer_if #(.W(NK)) bus ();

  key_debouncer #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_n_i       (bus.key_n),
    .key_level_o   (bus.key_level),
    .key_press_o   (bus.key_press),
    .key_release_o (bus.key_release),
    .key_repeat_o  (bus.key_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: raw pin history, acceptance judged over a window of past samples.
  bit hist [NK][HMAX];
  int n;
  int last_tog [NK];
  int press_edge [NK];
  bit lvl [NK];
  logic [NK-1:0] e_level, e_press, e_rel, e_rep;
  int cnt_press [NK];
  int cnt_rel [NK];
  int cnt_rep [NK];

  task automatic chk_vec(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NK; k++) lvl[k] = 1'b0;
    e_level = '0; e_press = '0; e_rel = '0; e_rep = '0;
  endtask

  task automatic model_reinit();
    for (int k = 0; k < NK; k++) begin
      hist[k][n]   = 1'b1;
      hist[k][n-1] = 1'b1;
      last_tog[k]  = n;
      lvl[k]       = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit ok;
    n++;
    e_press = '0; e_rel = '0; e_rep = '0;
    for (int k = 0; k < NK; k++) begin
      hist[k][n] = bus.key_n[k];
      ok = (n - last_tog[k]) >= DEB;
      if (ok) begin
        for (int m = n - DEB + 1; m <= n; m++)
          if ((!hist[k][m-2]) == lvl[k]) ok = 1'b0;
      end
      if (ok) begin
        lvl[k] = !lvl[k];
        last_tog[k] = n;
        if (lvl[k]) begin
          e_press[k] = 1'b1;
          press_edge[k] = n;
        end else begin
          e_rel[k] = 1'b1;
        end
      end
      if (lvl[k] && (n - press_edge[k]) >= RD && ((n - press_edge[k] - RD) % RP) == 0)
        e_rep[k] = 1'b1;
      e_level[k] = lvl[k];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_clear();
    #1;
    chk_vec("level", bus.key_level, e_level);
    chk_vec("press", bus.key_press, e_press);
    chk_vec("release", bus.key_release, e_rel);
    chk_vec("repeat", bus.key_repeat, e_rep);
    for (int k = 0; k < NK; k++) begin
      cnt_press[k] += int'(bus.key_press[k]);
      cnt_rel[k]   += int'(bus.key_release[k]);
      cnt_rep[k]   += int'(bus.key_repeat[k]);
    end
  endtask

  task automatic ticks(input int c);
    for (int i = 0; i < c; i++) tick();
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NK; k++) begin
      cnt_press[k] = 0; cnt_rel[k] = 0; cnt_rep[k] = 0;
    end
  endtask

  task automatic wait_level(input int k, input logic want, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.key_level[k] !== want && cyc < 40);
  endtask

  typedef struct {
    int key;
    int hold;
    int e_press;
    int e_rel;
    int e_rep;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int cyc;
    int run [NK];
    logic [NK-1:0] pv;

    vecs[0]  = '{0,  5, 0, 0, 0};
    vecs[1]  = '{1,  7, 0, 0, 0};
    vecs[2]  = '{2,  8, 1, 1, 0};
    vecs[3]  = '{0, 20, 1, 1, 0};
    vecs[4]  = '{2, 32, 1, 1, 0};
    vecs[5]  = '{2, 33, 1, 1, 1};
    vecs[6]  = '{3, 42, 1, 1, 1};
    vecs[7]  = '{3, 43, 1, 1, 2};
    vecs[8]  = '{2, 80, 1, 1, 5};
    vecs[9]  = '{1, 82, 1, 1, 5};
    vecs[10] = '{1, 83, 1, 1, 6};
    vecs[11] = '{0,  1, 0, 0, 0};

    n = 2;
    rst_n = 1'b0;
    bus.key_n = '1;
    model_clear();
    clear_counts();
    ticks(3);
    rst_n = 1'b1;
    model_reinit();
    ticks(5);

    // Clean press on key 0: level rises exactly 10 cycles after the edge.
    clear_counts();
    bus.key_n[0] = 1'b0;
    wait_level(0, 1'b1, cyc);
    chk_int("press_latency", cyc, DEB + 2);
    ticks(20 - cyc);
    chk_int("clean_press_cnt", cnt_press[0], 1);
    chk_int("clean_repeat_cnt", cnt_rep[0], 0);
    bus.key_n[0] = 1'b1;
    wait_level(0, 1'b0, cyc);
    chk_int("release_latency", cyc, DEB + 2);
    ticks(5);

    // Bounce on key 1 then settle low.
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      bus.key_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      ticks(3);
    end
    bus.key_n[1] = 1'b0;
    wait_level(1, 1'b1, cyc);
    chk_int("bounce_latency", cyc, DEB + 2);
    chk_int("bounce_press_cnt", cnt_press[1], 1);
    bus.key_n[1] = 1'b1;
    ticks(20);

    for (int v = 0; v < 12; v++) begin
      clear_counts();
      bus.key_n[vecs[v].key] = 1'b0;
      ticks(vecs[v].hold);
      bus.key_n[vecs[v].key] = 1'b1;
      ticks(30);
      chk_int($sformatf("vec%0d_press", v), cnt_press[vecs[v].key], vecs[v].e_press);
      chk_int($sformatf("vec%0d_release", v), cnt_rel[vecs[v].key], vecs[v].e_rel);
      chk_int($sformatf("vec%0d_repeat", v), cnt_rep[vecs[v].key], vecs[v].e_rep);
    end

    // Reset while key 3 is held.
    clear_counts();
    bus.key_n[3] = 1'b0;
    ticks(20);
    rst_n = 1'b0;
    #1;
    chk_vec("rst_level", bus.key_level, '0);
    ticks(3);
    chk_int("rst_no_release", cnt_rel[3], 0);
    rst_n = 1'b1;
    model_reinit();
    wait_level(3, 1'b1, cyc);
    chk_int("rst_repress_latency", cyc, DEB + 2);
    chk_int("rst_press_cnt", cnt_press[3], 2);
    bus.key_n[3] = 1'b1;
    ticks(20);

    // Keys 0 and 3 pressed together.
    bus.key_n[0] = 1'b0;
    bus.key_n[3] = 1'b0;
    ticks(DEB + 1);
    tick();
    pv = bus.key_press;
    chk_vec("simul_press", pv, 4'b1001);
    bus.key_n = '1;
    ticks(20);

    // Randomized runs with occasional reset, checked every cycle by the model.
    for (int k = 0; k < NK; k++) run[k] = 0;
    for (int i = 0; i < 2400; i++) begin
      for (int k = 0; k < NK; k++) begin
        if (run[k] == 0) begin
          bus.key_n[k] = ~bus.key_n[k];
          run[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(30, 75)) : int'($urandom_range(1, 12));
        end
        run[k]--;
      end
      if (i % 600 == 300) begin
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        model_reinit();
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
